// File: rtl/sram_resp_pkg.sv
// Shared types and constants for the sram_responder slice.
// Optional macro SRAM_RESP_LIVE_CORRECT_EN is consumed by sram_responder.
package sram_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  localparam logic LD_SEL_DATA = 1'b0;
  localparam logic LD_SEL_ANS  = 1'b1;

endpackage

// File: rtl/sram_resp_checker.sv
// Compare-scan engine: walks both arrays one entry per cycle and latches
// mismatch count, first failing address and a pass flag at DONE.
module sram_resp_checker
  import sram_resp_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  chk_start,
  input  logic [DATA_WIDTH-1:0] ram_word,
  input  logic [DATA_WIDTH-1:0] ans_word,
  output logic [ADDR_WIDTH-1:0] idx,
  output logic                  chk_busy,
  output logic                  chk_done,
  output logic                  scan_ok,
  output logic [ADDR_WIDTH:0]   mismatch_cnt,
  output logic [ADDR_WIDTH-1:0] first_bad_addr
);

  scan_state_t           state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt;
  logic [ADDR_WIDTH-1:0] fb_work;
  logic                  found;
  logic                  done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (chk_start) state_d = SCAN;
      SCAN:    if (idx == '1) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    chk_busy = (state_q == SCAN);
    chk_done = done_q;
  end

  // Working registers run during SCAN; published results change only at DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx            <= '0;
      cnt            <= '0;
      fb_work        <= '0;
      found          <= 1'b0;
      done_q         <= 1'b0;
      scan_ok        <= 1'b0;
      mismatch_cnt   <= '0;
      first_bad_addr <= '0;
    end else begin
      done_q <= (state_q == DONE);
      unique case (state_q)
        IDLE: begin
          if (chk_start) begin
            idx     <= '0;
            cnt     <= '0;
            fb_work <= '0;
            found   <= 1'b0;
          end
        end
        SCAN: begin
          idx <= idx + 1'b1;
          if (ram_word != ans_word) begin
            cnt <= cnt + 1'b1;
            if (!found) begin
              fb_work <= idx;
              found   <= 1'b1;
            end
          end
        end
        DONE: begin
          mismatch_cnt   <= cnt;
          first_bad_addr <= fb_work;
          scan_ok        <= (cnt == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sram_responder.sv
// Single-port memory target with host-loadable data/answer arrays and a compare scan.
// Define SRAM_RESP_LIVE_CORRECT_EN to drive correct from a live per-entry match vector.
module sram_responder
  import sram_resp_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic                  ld_sel,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  chk_start,
  output logic                  chk_busy,
  output logic                  chk_done,
  output logic                  correct,
  output logic [ADDR_WIDTH:0]   mismatch_cnt,
  output logic [ADDR_WIDTH-1:0] first_bad_addr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] ram [DEPTH];
  logic [DATA_WIDTH-1:0] ans [DEPTH];
  logic [ADDR_WIDTH-1:0] scan_idx;
  logic                  scan_ok;
  logic                  ram_we;
  logic                  ld_fire;

  assign ld_ready = !chk_busy && !en;
  assign ram_we   = en && we;
  assign ld_fire  = ld_valid && ld_ready;

  // Arrays are deliberately outside reset; ld_ready keeps the two writers exclusive.
  always_ff @(posedge clk) begin
    if (ram_we)
      ram[addr] <= data_i;
    else if (ld_fire && ld_sel == LD_SEL_DATA)
      ram[ld_addr] <= ld_data;
    if (ld_fire && ld_sel == LD_SEL_ANS)
      ans[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          data_o <= '0;
    else if (en && !we)  data_o <= ram[addr];
  end

  sram_resp_checker #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_checker (
    .clk            (clk),
    .reset          (reset),
    .chk_start      (chk_start),
    .ram_word       (ram[scan_idx]),
    .ans_word       (ans[scan_idx]),
    .idx            (scan_idx),
    .chk_busy       (chk_busy),
    .chk_done       (chk_done),
    .scan_ok        (scan_ok),
    .mismatch_cnt   (mismatch_cnt),
    .first_bad_addr (first_bad_addr)
  );

`ifdef SRAM_RESP_LIVE_CORRECT_EN
  logic [DEPTH-1:0] match;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match <= '0;
    end else if (ram_we) begin
      match[addr] <= (data_i == ans[addr]);
    end else if (ld_fire) begin
      if (ld_sel == LD_SEL_DATA) match[ld_addr] <= (ld_data == ans[ld_addr]);
      else                       match[ld_addr] <= (ram[ld_addr] == ld_data);
    end
  end

  assign correct = &match;
`else
  assign correct = scan_ok;
`endif

endmodule
